// File: rtl/xsleena_video_pkg.sv
// Shared definitions for the xsleena video colour path.
//   ch_e            : LUT channel select (R, G, B, or no-op)
//   LADDER_4X8      : resistor-ladder intensity curve for 4-bit codes / 8-bit outputs
//   ladder_default  : default LUT entry for any code/width combination
package xsleena_video_pkg;

  typedef enum logic [1:0] {
    CH_R    = 2'd0,
    CH_G    = 2'd1,
    CH_B    = 2'd2,
    CH_NONE = 2'd3
  } ch_e;

  // Measured ladder response of the original board; not a pure replication.
  localparam logic [7:0] LADDER_4X8 [16] = '{
    8'h00, 8'h10, 8'h20, 8'h30, 8'h3E, 8'h4E, 8'h5E, 8'h6E,
    8'h91, 8'hA1, 8'hB1, 8'hC1, 8'hCF, 8'hDF, 8'hEF, 8'hFF
  };

  // Ladder table for the native 4->8 case, otherwise the code bit-replicated
  // MSB-first: the code is concatenated with itself until at least out_bits
  // bits exist, then the surplus LSBs are dropped.
  function automatic logic [31:0] ladder_default(input int unsigned code,
                                                 input int unsigned in_bits,
                                                 input int unsigned out_bits);
    logic [63:0] acc;
    int unsigned n;
    if (in_bits == 4 && out_bits == 8) begin
      return {24'd0, LADDER_4X8[code[3:0]]};
    end
    acc = '0;
    n   = 0;
    for (int i = 0; i < 64; i++) begin
      if (n < out_bits) begin
        acc = (acc << in_bits) | 64'(code);
        n   = n + in_bits;
      end
    end
    acc = acc >> (n - out_bits);
    return 32'(acc);
  endfunction

endpackage

// File: rtl/xsleena_lut_ram.sv
// Single-write / single-read register array with a registered read port.
//   we/wr_addr/wr_data : write port, takes effect on the clock edge
//   rd_addr            : read address, sampled on the clock edge
//   rd_zero            : force the registered read data to zero
//   rd_data            : registered read data (old contents on a same-edge write)
module xsleena_lut_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  input  logic             rd_zero,
  output logic [WIDTH-1:0] rd_data
);

  // Contents are deliberately not reset; the owner fills them after reset.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_d, rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end

  // Reading the array before the edge gives read-before-write on collision.
  always_comb begin
    rd_data_d = rd_zero ? '0 : mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/xsleena_rgb_lut_stage.sv
// Three-channel palette-code to intensity expander.
//   pix_*      : input pixel (valid qualifier, R/G/B codes, blank flag)
//   bright     : global brightness, 255 = unity, sampled with the pixel
//   lut_*      : per-channel LUT write port and reinit request
//   ready      : LUTs hold a complete curve (RUN state)
//   rgb_*      : output pixel, two cycles after the input pixel
// Pixel flow: pix_valid is a pure qualifier travelling with the data; there is
// no backpressure, every cycle advances the pipeline and downstream must accept
// (or ignore) each cycle where rgb_valid is high.
module xsleena_rgb_lut_stage #(
  parameter int IN_BITS  = 4,
  parameter int OUT_BITS = 8
) (
  input  logic                clk,
  input  logic                RESETn,
  input  logic                pix_valid,
  input  logic [IN_BITS-1:0]  pix_r,
  input  logic [IN_BITS-1:0]  pix_g,
  input  logic [IN_BITS-1:0]  pix_b,
  input  logic                pix_blank,
  input  logic [7:0]          bright,
  input  logic                lut_we,
  input  logic [1:0]          lut_ch,
  input  logic [IN_BITS-1:0]  lut_addr,
  input  logic [OUT_BITS-1:0] lut_data,
  input  logic                lut_reinit,
  output logic                ready,
  output logic                rgb_valid,
  output logic [OUT_BITS-1:0] rgb_r,
  output logic [OUT_BITS-1:0] rgb_g,
  output logic [OUT_BITS-1:0] rgb_b,
  output logic                rgb_blank
);
  import xsleena_video_pkg::*;

  localparam int DEPTH = 2 ** IN_BITS;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // ---------------- init / run FSM ----------------
  logic [0:0]         state_d, state_q;
  logic [IN_BITS-1:0] init_cnt_d, init_cnt_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        // Counter wraps back to 0 on the last entry, ready for a later reinit.
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (lut_reinit) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign ready = (state_q == ST_RUN);

  // ---------------- LUT write port ----------------
  logic                in_init;
  logic                run_wr;
  logic [OUT_BITS-1:0] def_val;
  logic [IN_BITS-1:0]  wr_addr;
  logic [OUT_BITS-1:0] wr_data;
  logic [2:0]          we_ch;

  always_comb begin
    in_init  = (state_q == ST_INIT);
    // A reinit in the same cycle swallows the software write.
    run_wr   = ready && lut_we && !lut_reinit;
    def_val  = OUT_BITS'(ladder_default(32'(init_cnt_q), IN_BITS, OUT_BITS));
    wr_addr  = in_init ? init_cnt_q : lut_addr;
    wr_data  = in_init ? def_val : lut_data;
    we_ch[0] = in_init || (run_wr && ch_e'(lut_ch) == CH_R);
    we_ch[1] = in_init || (run_wr && ch_e'(lut_ch) == CH_G);
    we_ch[2] = in_init || (run_wr && ch_e'(lut_ch) == CH_B);
  end

  // ---------------- S1: LUT reads (registered inside the RAMs) ----------------
  logic [IN_BITS-1:0]  rd_addr [3];
  logic [OUT_BITS-1:0] lut_q   [3];

  assign rd_addr[0] = pix_r;
  assign rd_addr[1] = pix_g;
  assign rd_addr[2] = pix_b;

  for (genvar c = 0; c < 3; c++) begin : g_lut
    xsleena_lut_ram #(
      .DEPTH (DEPTH),
      .WIDTH (OUT_BITS)
    ) u_lut (
      .clk     (clk),
      .rst_n   (RESETn),
      .we      (we_ch[c]),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr[c]),
      .rd_zero (!ready),
      .rd_data (lut_q[c])
    );
  end

  logic       s1_valid_d, s1_valid_q;
  logic       s1_blank_d, s1_blank_q;
  logic [7:0] s1_bright_d, s1_bright_q;

  always_comb begin
    s1_valid_d  = pix_valid;
    s1_blank_d  = pix_blank;
    s1_bright_d = bright;
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      s1_valid_q  <= 1'b0;
      s1_blank_q  <= 1'b1;
      s1_bright_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_blank_q  <= s1_blank_d;
      s1_bright_q <= s1_bright_d;
    end
  end

  // ---------------- S2: brightness scale and blanking ----------------
  // (v * (bright + 1)) >> 8, truncated; bright = 255 is an exact identity.
  function automatic logic [OUT_BITS-1:0] scale(input logic [OUT_BITS-1:0] v,
                                                input logic [8:0]          k);
    logic [OUT_BITS+8:0] p;
    p = (OUT_BITS+9)'(v) * (OUT_BITS+9)'(k);
    return OUT_BITS'(p >> 8);
  endfunction

  logic [8:0]          k_s1;
  logic                rgb_valid_d, rgb_valid_q;
  logic                rgb_blank_d, rgb_blank_q;
  logic [OUT_BITS-1:0] rgb_r_d, rgb_r_q;
  logic [OUT_BITS-1:0] rgb_g_d, rgb_g_q;
  logic [OUT_BITS-1:0] rgb_b_d, rgb_b_q;

  always_comb begin
    k_s1        = {1'b0, s1_bright_q} + 9'd1;
    rgb_valid_d = s1_valid_q;
    rgb_blank_d = s1_blank_q;
    rgb_r_d     = s1_blank_q ? '0 : scale(lut_q[0], k_s1);
    rgb_g_d     = s1_blank_q ? '0 : scale(lut_q[1], k_s1);
    rgb_b_d     = s1_blank_q ? '0 : scale(lut_q[2], k_s1);
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      rgb_valid_q <= 1'b0;
      rgb_blank_q <= 1'b1;
      rgb_r_q     <= '0;
      rgb_g_q     <= '0;
      rgb_b_q     <= '0;
    end else begin
      rgb_valid_q <= rgb_valid_d;
      rgb_blank_q <= rgb_blank_d;
      rgb_r_q     <= rgb_r_d;
      rgb_g_q     <= rgb_g_d;
      rgb_b_q     <= rgb_b_d;
    end
  end

  assign rgb_valid = rgb_valid_q;
  assign rgb_blank = rgb_blank_q;
  assign rgb_r     = rgb_r_q;
  assign rgb_g     = rgb_g_q;
  assign rgb_b     = rgb_b_q;

endmodule

// File: tb/tb_xsleena_rgb_lut_stage.sv
`timescale 1ns/1ps
module tb_xsleena_rgb_lut_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic RESETn;

  // ---------------- DUT 1: IN_BITS=4, OUT_BITS=8 ----------------
  logic       pix_valid, pix_blank, lut_we, lut_reinit;
  logic [3:0] pix_r, pix_g, pix_b, lut_addr;
  logic [7:0] bright, lut_data;
  logic [1:0] lut_ch;
  logic       ready, rgb_valid, rgb_blank;
  logic [7:0] rgb_r, rgb_g, rgb_b;

  xsleena_rgb_lut_stage #(.IN_BITS(4), .OUT_BITS(8)) dut (
    .clk(clk), .RESETn(RESETn), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_blank(pix_blank),
    .bright(bright), .lut_we(lut_we), .lut_ch(lut_ch), .lut_addr(lut_addr),
    .lut_data(lut_data), .lut_reinit(lut_reinit), .ready(ready),
    .rgb_valid(rgb_valid), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .rgb_blank(rgb_blank)
  );

  // ---------------- DUT 2: IN_BITS=5, OUT_BITS=10 ----------------
  logic       p2_valid, p2_blank, p2_we, p2_reinit;
  logic [4:0] p2_r, p2_g, p2_b, p2_addr;
  logic [7:0] p2_bright;
  logic [9:0] p2_data;
  logic [1:0] p2_ch;
  logic       ready2, rgb2_valid, rgb2_blank;
  logic [9:0] rgb2_r, rgb2_g, rgb2_b;

  xsleena_rgb_lut_stage #(.IN_BITS(5), .OUT_BITS(10)) dut2 (
    .clk(clk), .RESETn(RESETn), .pix_valid(p2_valid),
    .pix_r(p2_r), .pix_g(p2_g), .pix_b(p2_b), .pix_blank(p2_blank),
    .bright(p2_bright), .lut_we(p2_we), .lut_ch(p2_ch), .lut_addr(p2_addr),
    .lut_data(p2_data), .lut_reinit(p2_reinit), .ready(ready2),
    .rgb_valid(rgb2_valid), .rgb_r(rgb2_r), .rgb_g(rgb2_g), .rgb_b(rgb2_b),
    .rgb_blank(rgb2_blank)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] def_tab [16] = '{
    8'h00, 8'h10, 8'h20, 8'h30, 8'h3E, 8'h4E, 8'h5E, 8'h6E,
    8'h91, 8'hA1, 8'hB1, 8'hC1, 8'hCF, 8'hDF, 8'hEF, 8'hFF
  };

  // Model: LUT contents, ready flag, entries written so far during init, and
  // the expected output queue {valid, blank, r, g, b}; exp_q[0] is what the
  // outputs must show now, exp_q[1] what they will show after the next edge.
  localparam logic [25:0] RST_ENTRY = {1'b0, 1'b1, 24'h000000};
  logic [7:0]  lut_m [3][16];
  bit          m_ready;
  int          m_init;
  logic [25:0] exp_q[$];
  logic [7:0]  mv [3];
  logic [25:0] me;

  function automatic logic [7:0] scale_m(input logic [7:0] v, input logic [7:0] br);
    int unsigned p;
    p = int'(v) * (int'(br) + 1);
    return 8'(p / 256);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: advances once per clock edge, resets asynchronously.
  initial begin
    exp_q   = '{RST_ENTRY, RST_ENTRY};
    m_ready = 0;
    m_init  = 0;
    forever begin
      @(posedge clk or negedge RESETn);
      if (RESETn !== 1'b1) begin
        exp_q   = '{RST_ENTRY, RST_ENTRY};
        m_ready = 0;
        m_init  = 0;
      end else begin
        mv[0] = m_ready ? lut_m[0][pix_r] : 8'h00;
        mv[1] = m_ready ? lut_m[1][pix_g] : 8'h00;
        mv[2] = m_ready ? lut_m[2][pix_b] : 8'h00;
        if (pix_blank) me = {pix_valid, 1'b1, 24'h000000};
        else me = {pix_valid, 1'b0, scale_m(mv[0], bright),
                   scale_m(mv[1], bright), scale_m(mv[2], bright)};
        exp_q.push_back(me);
        void'(exp_q.pop_front());
        if (!m_ready) begin
          for (int c = 0; c < 3; c++) lut_m[c][m_init] = def_tab[m_init];
          if (m_init == 15) begin m_ready = 1; m_init = 0; end
          else m_init++;
        end else if (lut_reinit) begin
          m_ready = 0;
        end else if (lut_we && lut_ch != 2'd3) begin
          lut_m[lut_ch][lut_addr] = lut_data;
        end
      end
    end
  end

  // Compare process: every negative edge, DUT 1 against the model.
  initial begin
    forever begin
      @(negedge clk);
      n_checks++;
      if ({rgb_valid, rgb_blank, rgb_r, rgb_g, rgb_b} !== exp_q[0] || ready !== m_ready) begin
        n_fail++;
        $display("FAIL model_cmp: got v=%b bl=%b rgb=%h%h%h rdy=%b expected v=%b bl=%b rgb=%h rdy=%b (t=%0t)",
                 rgb_valid, rgb_blank, rgb_r, rgb_g, rgb_b, ready,
                 exp_q[0][25], exp_q[0][24], exp_q[0][23:0], m_ready, $time);
      end
    end
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500us");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1ns after a rising edge.
  task automatic send(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                      input logic blk, input logic [7:0] br);
    pix_valid = 1'b1; pix_r = r; pix_g = g; pix_b = b; pix_blank = blk; bright = br;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string name, input int start, input int exp_cyc);
    int cyc;
    cyc = start;
    while (ready !== 1'b1 && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check(name, 32'(cyc), 32'(exp_cyc));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RESETn = 1'b0;
    pix_valid = 1'b1; pix_r = '0; pix_g = '0; pix_b = '0; pix_blank = 1'b0;
    bright = 8'd255; lut_we = 1'b0; lut_ch = 2'd0; lut_addr = '0; lut_data = '0;
    lut_reinit = 1'b0;
    p2_valid = 1'b0; p2_r = '0; p2_g = '0; p2_b = '0; p2_blank = 1'b0;
    p2_bright = 8'd255; p2_we = 1'b0; p2_ch = 2'd0; p2_addr = '0; p2_data = '0;
    p2_reinit = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rgb_valid), 32'h0);
    check("rst_blank", 32'(rgb_blank), 32'h1);
    check("rst_rgb",   32'({rgb_r, rgb_g, rgb_b}), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);

    // Init with valid pixels flowing.
    RESETn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pix_r = 4'($urandom_range(0, 15));
      pix_g = 4'($urandom_range(0, 15));
      pix_b = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    check("init_valid", 32'(rgb_valid), 32'h1);
    check("init_rgb",   32'({rgb_r, rgb_g, rgb_b}), 32'h0);
    wait_ready("init_len", 10, 16);

    // Default curve at unity brightness.
    send(4'h8, 4'hC, 4'hF, 1'b0, 8'd255);
    check("unity_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'h91CFFF);
    for (int c = 0; c < 16; c++) begin
      send(4'(c), 4'(c), 4'(c), 1'b0, 8'd255);
      check($sformatf("sweep_%0d", c), 32'(rgb_r), 32'(def_tab[c]));
    end

    // Brightness.
    send(4'hF, 4'h0, 4'h0, 1'b0, 8'd127);
    check("bright127", 32'(rgb_r), 32'h7F);
    send(4'hF, 4'h0, 4'h0, 1'b0, 8'd0);
    check("bright0", 32'(rgb_r), 32'h00);

    // Write/read collision on G entry 3.
    pix_r = 4'h3; pix_g = 4'h3; pix_b = 4'h3; bright = 8'd255;
    lut_we = 1'b1; lut_ch = 2'd1; lut_addr = 4'h3; lut_data = 8'hAA;
    @(posedge clk); #1;
    lut_we = 1'b0;
    @(posedge clk); #1;
    check("collide_old", 32'(rgb_g), 32'h30);
    send(4'h3, 4'h3, 4'h3, 1'b0, 8'd255);
    check("collide_new", 32'({rgb_r, rgb_g, rgb_b}), 32'h30AA30);

    // Channel 3 write is a no-op.
    pix_r = 4'h5; pix_g = 4'h5; pix_b = 4'h5;
    lut_we = 1'b1; lut_ch = 2'd3; lut_addr = 4'h5; lut_data = 8'h11;
    @(posedge clk); #1;
    lut_we = 1'b0;
    send(4'h5, 4'h5, 4'h5, 1'b0, 8'd255);
    check("ch3_noop", 32'({rgb_r, rgb_g, rgb_b}), 32'h4E4E4E);

    // Blanking.
    send(4'hF, 4'hF, 4'hF, 1'b1, 8'd255);
    check("blank_rgb", 32'({rgb_r, rgb_g, rgb_b}), 32'h0);
    check("blank_flag", 32'(rgb_blank), 32'h1);

    // Reinit beats a same-cycle write.
    pix_blank = 1'b0;
    lut_reinit = 1'b1; lut_we = 1'b1; lut_ch = 2'd1; lut_addr = 4'h3; lut_data = 8'h77;
    @(posedge clk); #1;
    lut_reinit = 1'b0; lut_we = 1'b0;
    check("reinit_ready", 32'(ready), 32'h0);
    wait_ready("reinit_len", 0, 16);
    send(4'h3, 4'h3, 4'h3, 1'b0, 8'd255);
    check("reinit_restore", 32'({rgb_r, rgb_g, rgb_b}), 32'h303030);

    // Asynchronous reset in RUN with non-zero outputs.
    send(4'hF, 4'hF, 4'hF, 1'b0, 8'd255);
    #2 RESETn = 1'b0;
    #1;
    check("arst_run", 32'({ready, rgb_valid, rgb_blank, rgb_r, rgb_g, rgb_b}), 32'h1000000);
    @(posedge clk); #1;
    RESETn = 1'b1;
    // Asynchronous reset at init count 7.
    repeat (7) @(posedge clk);
    #2 RESETn = 1'b0;
    #1;
    check("arst_init", 32'({ready, rgb_valid, rgb_blank, rgb_r, rgb_g, rgb_b}), 32'h1000000);
    @(posedge clk); #1;
    RESETn = 1'b1;
    wait_ready("rerun_len", 0, 16);
    send(4'h8, 4'h0, 4'hF, 1'b0, 8'd255);
    check("rerun_table", 32'({rgb_r, rgb_g, rgb_b}), 32'h9100FF);

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      pix_valid  = 1'($urandom_range(0, 1));
      pix_r      = 4'($urandom_range(0, 15));
      pix_g      = 4'($urandom_range(0, 15));
      pix_b      = 4'($urandom_range(0, 15));
      pix_blank  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       bright = 8'd255;
        1:       bright = 8'd0;
        default: bright = 8'($urandom_range(0, 255));
      endcase
      lut_we     = ($urandom_range(0, 3) == 0);
      lut_ch     = 2'($urandom_range(0, 3));
      lut_addr   = 4'($urandom_range(0, 15));
      lut_data   = 8'($urandom_range(0, 255));
      lut_reinit = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
    end
    lut_we = 1'b0; lut_reinit = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Wide variant: replicated default curve, latency 2.
    check("p2_ready", 32'(ready2), 32'h1);
    p2_valid = 1'b1; p2_r = 5'h1F; p2_g = 5'h10; p2_b = 5'h00;
    @(posedge clk); #1;
    p2_valid = 1'b0;
    check("p2_lat1", 32'(rgb2_valid), 32'h0);
    @(posedge clk); #1;
    check("p2_lat2", 32'(rgb2_valid), 32'h1);
    check("p2_r", 32'(rgb2_r), 32'h3FF);
    check("p2_g", 32'(rgb2_g), 32'h210);
    check("p2_b", 32'(rgb2_b), 32'h000);
    @(posedge clk); #1;
    check("p2_lat3", 32'(rgb2_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xsleena_rgb_lut_stage.md
Name: xsleena_rgb_lut_stage

Overview:
- Parametrised 3-channel video colour expander between the palette RAM output and the video DAC/scaler.
- Maps IN_BITS-per-channel palette codes to OUT_BITS-per-channel linear intensity through three loadable per-channel LUTs, then applies a global brightness factor and blanking.
- Registered 2-stage pipeline with a valid strobe.
- A post-reset init FSM fills all LUTs with the resistor-ladder default curve, so software and test loaders may override individual entries.

Parameters:
- IN_BITS, 4, palette code width per channel; LUT depth is 2**IN_BITS.
- OUT_BITS, 8, output intensity width per channel.

Ports:
- clk  in  1  pixel-domain clock
- RESETn  in  1  asynchronous, active-low reset
- pix_valid  in  1  input pixel qualifier
- pix_r, pix_g, pix_b  in  IN_BITS each  palette codes
- pix_blank  in  1  blanking flag travelling with the pixel
- bright  in  8  global brightness; 255 = unity
- lut_we  in  1  LUT write strobe
- lut_ch  in  2  0=R, 1=G, 2=B; 3=no-op
- lut_addr  in  IN_BITS  LUT entry index
- lut_data  in  OUT_BITS  LUT entry value
- lut_reinit  in  1  single-cycle request to reload defaults
- ready  out  1  high when LUTs are initialised (RUN state)
- rgb_valid  out  1  output qualifier
- rgb_r, rgb_g, rgb_b  out  OUT_BITS each  expanded intensities
- rgb_blank  out  1  delayed pix_blank

Behaviour:
- Reset: RESETn low asynchronously forces the following, whatever the state, including mid-init:
  - FSM=INIT, init counter=0, ready=0.
  - rgb_valid=0, rgb_r/g/b=0, rgb_blank=1.
  - LUT contents are undefined until INIT completes.
- FSM INIT:
  - Each cycle, writes default[cnt] into all three LUTs and increments cnt.
  - After entry 2**IN_BITS-1 is written, moves to RUN next cycle and sets ready=1.
  - INIT lasts exactly 2**IN_BITS cycles after reset deassertion.
  - lut_we is ignored during INIT.
- FSM RUN:
  - lut_we with lut_ch in 0..2 writes lut_data at lut_addr on that clock edge.
  - lut_ch=3 makes no change.
  - lut_reinit=1 returns the FSM to INIT (cnt=0, ready=0) on the next edge.
  - lut_reinit has priority over a same-cycle lut_we; that write is dropped.
- Default curve, OUT_BITS=8, IN_BITS=4: 00,10,20,30,3E,4E,5E,6E,91,A1,B1,C1,CF,DF,EF,FF.
- Default curve, any other parameter combination: the code bit-replicated MSB-first to fill OUT_BITS. Example: IN_BITS=5, OUT_BITS=8 maps code c to {c, c[4:2]}.
- Pipeline stages (fixed latency 2 from pix_valid to rgb_valid; runs every cycle and is never stalled):
  - S1 registers the LUT reads of pix_r/g/b, plus valid and blank.
  - S2 registers the scaled result: out = (lut * (bright+1)) >> 8, using an OUT_BITS+9-bit intermediate with no rounding. bright=255 gives identity; bright=0 gives lut>>8, which is 0 for OUT_BITS<=8.
  - bright is sampled in S1 alongside the pixel.
- Blanking: if the S1 blank flag is set, S2 outputs 0 on all channels regardless of LUT or brightness. rgb_blank equals that flag.
- While ready=0 (INIT): S1 forces its LUT outputs to 0. valid and blank still propagate, so timing toward the scaler is preserved.
- Write/read collision: a write to the same channel and address as a same-cycle lookup returns the old entry (read-before-write). The new entry is seen from the next cycle.
- rgb_valid=0 does not zero the data outputs. Downstream must qualify data with rgb_valid.

Decomposition:
- Shared package xsleena_video_pkg holds:
  - the channel enum (CH_R, CH_G, CH_B, CH_NONE);
  - the 16-entry default ladder table constant;
  - the function computing the bit-replicated default for arbitrary widths.
- One sub-module is natural: xsleena_lut_ram, a 1-write/1-read synchronous-read register array parametrised by depth and width, instantiated three times.
- The FSM, scaler and pipeline stay in the top module.

Test Plan:
- Release RESETn with pix_valid=1 held → ready rises exactly 16 cycles after release. rgb_valid=1 with rgb_r/g/b=0 throughout INIT.
- After ready, bright=255, pix_r=4'h8, pix_g=4'hC, pix_b=4'hF → two cycles later rgb = 91/CF/FF. Sweep all 16 codes and check the full default table.
- bright=127, pix_r=4'hF (FF) → rgb_r = 0x7F. Repeat with bright=0 → rgb_r = 0x00.
- lut_we with lut_ch=1, lut_addr=3, lut_data=0xAA, and pix_g=3 in the same cycle → that pixel returns 0x30. The next pixel with pix_g=3 returns 0xAA; R and B at code 3 stay 0x30. Repeat with lut_ch=3 → no change anywhere.
- pix_blank=1 with pix_r=F, bright=255 → rgb_r=0 and rgb_blank=1 two cycles later. Assert lut_reinit together with a lut_we → ready drops, the write is lost, and the default is restored after 16 cycles.
- Assert RESETn low at init count 7 → outputs zero immediately, with no clock edge needed. After release, the full 16-cycle INIT reruns from entry 0.
- Parameter set IN_BITS=5, OUT_BITS=10 → code 5'h1F maps to 0x3FF, code 5'h10 maps to 10'b1000010000; latency is still 2.
